// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache between the fetch stage and the memory controller.
// Optional hit/miss statistics counters are enabled with ICACHE_STATS_EN.
module icache_direct #(
    parameter int NFRAMES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
`ifdef ICACHE_STATS_EN
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`else
    input  logic [31:0] iload
`endif
);

    localparam int IDX_W = $clog2(NFRAMES);
    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]       state;
    logic [29:0]      miss_word;
    logic [NFRAMES-1:0] valid;
    logic [TAG_W-1:0] tags [NFRAMES];
    logic [31:0]      data [NFRAMES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic             hit;
    logic             miss_start;
    logic             fill_done;
    logic [1:0]       unused_byte_offset;

    assign idx      = imemaddr[IDX_W+1:2];
    assign tag      = imemaddr[31:IDX_W+2];
    assign miss_idx = miss_word[IDX_W-1:0];
    assign miss_tag = miss_word[29:IDX_W];
    assign unused_byte_offset = imemaddr[1:0];

    assign hit        = (state == IDLE) && imemREN && valid[idx] && (tags[idx] == tag);
    assign miss_start = (state == IDLE) && imemREN && !hit;
    assign fill_done  = (state == FETCH) && !iwait;

    assign ihit     = hit;
    assign imemload = hit ? data[idx] : 32'h0;
    assign iREN     = (state == FETCH);
    assign iaddr    = (state == FETCH) ? {miss_word, 2'b00} : 32'h0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_word <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_start) begin
                        miss_word <= imemaddr[31:2];
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A flush always wins over a fill landing in the same cycle, so that fill is dropped.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (fill_done) begin
            valid[miss_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[miss_idx] <= miss_tag;
            data[miss_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (hit && (hit_count != 32'hFFFF_FFFF))
                hit_count <= hit_count + 32'h1;
            if (miss_start && (miss_count != 32'hFFFF_FFFF))
                miss_count <= miss_count + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct; checks the packed tuple {iREN, iaddr, ihit, imemload}.
// Define ICACHE_STATS_EN to also check the statistics counters.
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    logic [65:0] obs;
    assign obs = {iREN, iaddr, ihit, imemload};

    int passed = 0;
    int total  = 0;

    icache_direct #(.NFRAMES(16)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .flush(flush),
        .ihit(ihit),
        .imemload(imemload),
        .iREN(iREN),
        .iaddr(iaddr),
        .iwait(iwait),
`ifdef ICACHE_STATS_EN
        .iload(iload),
        .hit_count(hit_count),
        .miss_count(miss_count)
`else
        .iload(iload)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Miss then fill one frame with no intermediate wait cycles.
    task automatic fill(input logic [31:0] a, input logic [31:0] w);
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
        step();
        iwait = 1'b0; iload = w;
        step();
        iwait = 1'b1;
    endtask

    task automatic test_reset;
        logic [65:0] exp;
        nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; flush = 1'b0;
        iwait = 1'b1; iload = 32'h0;
        #1;
        exp = {1'b0, 32'h0, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL reset_outputs: got %h want %h", obs, exp); else passed++;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        step();
    endtask

    task automatic test_miss_fill;
        logic [65:0] exp;
        imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1;
        #1;
        exp = {1'b0, 32'h0, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL miss_detect: got %h want %h", obs, exp); else passed++;
        step();
        exp = {1'b1, 32'h0, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL fetch_wait1: got %h want %h", obs, exp); else passed++;
        step();
        total++;
        if (obs !== exp) $display("[TB] FAIL fetch_wait2: got %h want %h", obs, exp); else passed++;
        iwait = 1'b0; iload = 32'h3C010001;
        #1;
        total++;
        if (obs !== exp) $display("[TB] FAIL fetch_fill_cycle: got %h want %h", obs, exp); else passed++;
        step();
        iwait = 1'b1;
        #1;
        exp = {1'b0, 32'h0, 1'b1, 32'h3C010001}; total++;
        if (obs !== exp) $display("[TB] FAIL hit_after_fill: got %h want %h", obs, exp); else passed++;
    endtask

    task automatic test_repeat_hit;
        logic [65:0] exp;
        step();
        exp = {1'b0, 32'h0, 1'b1, 32'h3C010001}; total++;
        if (obs !== exp) $display("[TB] FAIL repeat_hit: got %h want %h", obs, exp); else passed++;
        step();
        imemREN = 1'b0;
        #1;
        exp = {1'b0, 32'h0, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL no_request_no_hit: got %h want %h", obs, exp); else passed++;
`ifdef ICACHE_STATS_EN
        total++;
        if (hit_count !== 32'd2) $display("[TB] FAIL hit_count: got %0d want 2", hit_count); else passed++;
        total++;
        if (miss_count !== 32'd1) $display("[TB] FAIL miss_count: got %0d want 1", miss_count); else passed++;
`endif
    endtask

    task automatic test_collision;
        logic [65:0] exp;
        fill(32'h04, 32'hAAAA0004);
        #1;
        exp = {1'b0, 32'h0, 1'b1, 32'hAAAA0004}; total++;
        if (obs !== exp) $display("[TB] FAIL hit_04: got %h want %h", obs, exp); else passed++;
        imemaddr = 32'h44;
        #1;
        exp = {1'b0, 32'h0, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL miss_44: got %h want %h", obs, exp); else passed++;
        step();
        exp = {1'b1, 32'h44, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL fetch_44: got %h want %h", obs, exp); else passed++;
        iwait = 1'b0; iload = 32'hBBBB0044;
        step();
        iwait = 1'b1;
        #1;
        exp = {1'b0, 32'h0, 1'b1, 32'hBBBB0044}; total++;
        if (obs !== exp) $display("[TB] FAIL hit_44: got %h want %h", obs, exp); else passed++;
        imemaddr = 32'h04;
        #1;
        exp = {1'b0, 32'h0, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL evicted_04: got %h want %h", obs, exp); else passed++;
        fill(32'h04, 32'hAAAA0004);
    endtask

    task automatic test_branch_change;
        logic [65:0] exp;
        imemaddr = 32'h10; iwait = 1'b1;
        step();
        imemaddr = 32'h20;
        #1;
        exp = {1'b1, 32'h10, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL iaddr_hold_a: got %h want %h", obs, exp); else passed++;
        step();
        total++;
        if (obs !== exp) $display("[TB] FAIL iaddr_hold_b: got %h want %h", obs, exp); else passed++;
        iwait = 1'b0; iload = 32'hCCCC0010;
        step();
        iwait = 1'b1;
        #1;
        exp = {1'b0, 32'h0, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL miss_20: got %h want %h", obs, exp); else passed++;
        step();
        exp = {1'b1, 32'h20, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL fetch_20: got %h want %h", obs, exp); else passed++;
        iwait = 1'b0; iload = 32'hDDDD0020;
        step();
        iwait = 1'b1;
        #1;
        exp = {1'b0, 32'h0, 1'b1, 32'hDDDD0020}; total++;
        if (obs !== exp) $display("[TB] FAIL hit_20: got %h want %h", obs, exp); else passed++;
        imemaddr = 32'h10;
        #1;
        exp = {1'b0, 32'h0, 1'b1, 32'hCCCC0010}; total++;
        if (obs !== exp) $display("[TB] FAIL hit_10: got %h want %h", obs, exp); else passed++;
    endtask

    task automatic test_flush;
        logic [65:0] exp;
        logic [31:0] addrs [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        fill(32'h0, 32'h11110000);
        fill(32'h4, 32'h11110004);
        fill(32'h8, 32'h11110008);
        flush = 1'b1;
        #1;
        exp = {1'b0, 32'h0, 1'b1, 32'h11110008}; total++;
        if (obs !== exp) $display("[TB] FAIL hit_during_flush: got %h want %h", obs, exp); else passed++;
        step();
        flush = 1'b0;
        exp = {1'b0, 32'h0, 1'b0, 32'h0};
        for (int i = 0; i < 3; i++) begin
            imemaddr = addrs[i];
            #1;
            total++;
            if (obs !== exp) $display("[TB] FAIL flushed_%0h: got %h want %h", addrs[i], obs, exp); else passed++;
        end
        imemaddr = 32'hC; iwait = 1'b1;
        step();
        exp = {1'b1, 32'hC, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL fetch_0c: got %h want %h", obs, exp); else passed++;
        flush = 1'b1; iwait = 1'b0; iload = 32'hEEEE000C;
        step();
        flush = 1'b0; iwait = 1'b1;
        #1;
        exp = {1'b0, 32'h0, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL fill_dropped_0c: got %h want %h", obs, exp); else passed++;
    endtask

    task automatic test_ren_drop;
        logic [65:0] exp;
        imemaddr = 32'h30; iwait = 1'b1;
        step();
        imemREN = 1'b0; iwait = 1'b0; iload = 32'hFFFF0030;
        #1;
        exp = {1'b1, 32'h30, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL fetch_30_no_ren: got %h want %h", obs, exp); else passed++;
        step();
        iwait = 1'b1;
        #1;
        exp = {1'b0, 32'h0, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL no_hit_without_ren: got %h want %h", obs, exp); else passed++;
        imemREN = 1'b1;
        #1;
        exp = {1'b0, 32'h0, 1'b1, 32'hFFFF0030}; total++;
        if (obs !== exp) $display("[TB] FAIL hit_30_installed: got %h want %h", obs, exp); else passed++;
    endtask

    task automatic test_reset_mid_fetch;
        logic [65:0] exp;
        imemaddr = 32'h40; iwait = 1'b1;
        step();
        exp = {1'b1, 32'h40, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL fetch_40: got %h want %h", obs, exp); else passed++;
        nRST = 1'b0;
        #1;
        exp = {1'b0, 32'h0, 1'b0, 32'h0}; total++;
        if (obs !== exp) $display("[TB] FAIL async_reset_fetch: got %h want %h", obs, exp); else passed++;
`ifdef ICACHE_STATS_EN
        total++;
        if (hit_count !== 32'd0) $display("[TB] FAIL hit_count_reset: got %0d want 0", hit_count); else passed++;
        total++;
        if (miss_count !== 32'd0) $display("[TB] FAIL miss_count_reset: got %0d want 0", miss_count); else passed++;
`endif
        @(negedge CLK);
        nRST = 1'b1;
        imemaddr = 32'h30;
        #1;
        total++;
        if (obs !== exp) $display("[TB] FAIL frames_invalid_after_reset: got %h want %h", obs, exp); else passed++;
        imemREN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_repeat_hit();
        test_collision();
        test_branch_change();
        test_flush();
        test_ren_drop();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
